// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//
// SRAM-like instruction port between the fetch stage (master) and the
// instruction memory (slave). One request may be outstanding at a time.
//
// Signals
//   inst_req      master->slave  fetch request
//   inst_addr     master->slave  fetch address (stable while req && !addr_ok)
//   inst_addr_ok  slave->master  request accepted this cycle
//   inst_data_ok  slave->master  read data valid this cycle
//   inst_rdata    slave->master  read data
// ----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register. Owns the fetch PC,
// drives a single-outstanding SRAM-like instruction port and hands
// instructions to decode. Delayed branches redirect after their delay slot;
// exception redirects take effect immediately and cancel any fetch in flight.
// Cycles without a ready instruction load a NOP bubble (instr 0, valid 0).
//
// Parameters
//   RESET_PC             first fetch address after reset
//
// Ports
//   clk                  clock, rising edge
//   rst                  synchronous active-high reset
//   inst_bus             instruction port (fetch_stage_if.master)
//   i_stall_D            decode holds, D register keeps its contents
//   i_flush_D            D register becomes a bubble (beats stall/delivery)
//   i_is_branch_D        valid instruction in D has a delay slot
//   i_branch_taken_D     that branch redirects
//   i_branch_target_D    redirect target
//   i_exc_redirect       exception/eret redirect, highest priority
//   i_exc_pc             exception/eret target
//   o_instr_D            instruction to decode (0 = bubble)
//   o_pc_D               PC of o_instr_D
//   o_valid_D            o_instr_D is a real instruction
//   o_is_in_delayslot_D  o_instr_D sits in a branch delay slot
//   o_adel_D             fetch address was misaligned
//
// Build option
//   FETCH_ADEL_EN        when defined, a misaligned pc_F issues no request and
//                        instead delivers an address-error bubble to D; when
//                        undefined o_adel_D is tied low and pc_F[1:0] is sent
//                        to memory as-is.
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        inst_bus,
    input  logic                 i_stall_D,
    input  logic                 i_flush_D,
    input  logic                 i_is_branch_D,
    input  logic                 i_branch_taken_D,
    input  logic [31:0]          i_branch_target_D,
    input  logic                 i_exc_redirect,
    input  logic [31:0]          i_exc_pc,
    output logic [31:0]          o_instr_D,
    output logic [31:0]          o_pc_D,
    output logic                 o_valid_D,
    output logic                 o_is_in_delayslot_D,
    output logic                 o_adel_D
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,   // request pc_F, waiting for addr_ok
        S_WAIT   = 2'd1,   // request accepted, waiting for data_ok
        S_CANCEL = 2'd2,   // data of a redirected-away fetch still to drain
        S_HOLD   = 2'd3    // data arrived while decode stalled, kept in r_buf
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc_F;
    logic [31:0] r_buf;
    logic        r_ds_flag;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;

    logic [31:0] r_instr_D;
    logic [31:0] r_pc_D;
    logic        r_valid_D;
    logic        r_ds_D;

    logic        w_misaligned;
    logic        w_accept;
    logic        w_fetch_done;
    logic        w_buf_load;
    logic        w_adel_fire;
    logic [31:0] w_deliver_word;
    logic        w_capture;
    logic        w_ds_eff;
    logic        w_pend_eff;
    logic [31:0] w_pend_pc_eff;
    logic [31:0] w_pc_next;

`ifdef FETCH_ADEL_EN
    assign w_misaligned = (r_pc_F[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // No request while in reset, so inst_req first rises in the cycle after
    // rst is released.
    assign inst_bus.inst_req  = (r_state == S_REQ) && !rst && !w_misaligned;
    assign inst_bus.inst_addr = r_pc_F;

    assign w_accept       = inst_bus.inst_req && inst_bus.inst_addr_ok;
    assign w_deliver_word = (r_state == S_HOLD) ? r_buf : inst_bus.inst_rdata;

    // A branch sitting in D is captured on the edge that lets it leave D.
    // If the delay-slot word is delivered on that very edge (possible when it
    // was parked in r_buf during a long stall), the capture is forwarded so
    // the delay slot is still marked and the redirect still applies.
    assign w_capture     = r_valid_D && i_is_branch_D && !i_stall_D && !i_exc_redirect;
    assign w_ds_eff      = r_ds_flag || w_capture;
    assign w_pend_eff    = r_pend_valid || (w_capture && i_branch_taken_D);
    assign w_pend_pc_eff = (w_capture && i_branch_taken_D) ? i_branch_target_D : r_pend_pc;

    // Only the delay slot itself may consume a pending redirect.
    assign w_pc_next = (w_ds_eff && w_pend_eff) ? w_pend_pc_eff : (r_pc_F + 32'd4);

    always_comb begin
        w_state_nxt  = r_state;
        w_fetch_done = 1'b0;
        w_buf_load   = 1'b0;
        w_adel_fire  = 1'b0;
        case (r_state)
            S_REQ: begin
                if (i_exc_redirect) begin
                    // An accepted request would return stale data: drain it.
                    w_state_nxt = w_accept ? S_CANCEL : S_REQ;
                end else if (w_misaligned) begin
                    w_adel_fire = !i_stall_D;
                end else if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_exc_redirect) begin
                    w_state_nxt = inst_bus.inst_data_ok ? S_REQ : S_CANCEL;
                end else if (inst_bus.inst_data_ok) begin
                    if (!i_stall_D) begin
                        w_fetch_done = 1'b1;
                        w_state_nxt  = S_REQ;
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (i_exc_redirect) begin
                    w_state_nxt = S_REQ;
                end else if (!i_stall_D) begin
                    w_fetch_done = 1'b1;
                    w_state_nxt  = S_REQ;
                end
            end
            S_CANCEL: begin
                if (inst_bus.inst_data_ok) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc_F       <= RESET_PC;
            r_ds_flag    <= 1'b0;
            r_pend_valid <= 1'b0;
            r_instr_D    <= 32'd0;
            r_pc_D       <= 32'd0;
            r_valid_D    <= 1'b0;
            r_ds_D       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (i_exc_redirect) begin
                r_pc_F       <= i_exc_pc;
                r_ds_flag    <= 1'b0;
                r_pend_valid <= 1'b0;
            end else if (w_fetch_done) begin
                // PC advances even when a flush throws the delivered word away.
                r_pc_F       <= w_pc_next;
                r_ds_flag    <= 1'b0;
                r_pend_valid <= w_pend_eff && !w_ds_eff;
            end else begin
                r_ds_flag    <= w_ds_eff;
                r_pend_valid <= w_pend_eff;
            end

            if (i_exc_redirect || i_flush_D) begin
                r_instr_D <= 32'd0;
                r_valid_D <= 1'b0;
                r_ds_D    <= 1'b0;
            end else if (w_fetch_done) begin
                r_instr_D <= w_deliver_word;
                r_pc_D    <= r_pc_F;
                r_valid_D <= 1'b1;
                r_ds_D    <= w_ds_eff;
            end else if (w_adel_fire) begin
                r_instr_D <= 32'd0;
                r_pc_D    <= r_pc_F;
                r_valid_D <= 1'b1;
                r_ds_D    <= w_ds_eff;
            end else if (!i_stall_D) begin
                r_instr_D <= 32'd0;
                r_valid_D <= 1'b0;
                r_ds_D    <= 1'b0;
            end
        end
    end

    // Datapath-only registers: their contents matter only while the FSM or
    // pend_valid says they are live, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_buf_load) begin
            r_buf <= inst_bus.inst_rdata;
        end
        r_pend_pc <= w_pend_pc_eff;
    end

`ifdef FETCH_ADEL_EN
    logic r_adel_D;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adel_D <= 1'b0;
        end else if (i_exc_redirect || i_flush_D || w_fetch_done) begin
            r_adel_D <= 1'b0;
        end else if (w_adel_fire) begin
            r_adel_D <= 1'b1;
        end else if (!i_stall_D) begin
            r_adel_D <= 1'b0;
        end
    end

    assign o_adel_D = r_adel_D;
`else
    assign o_adel_D = 1'b0;
`endif

    assign o_instr_D           = r_instr_D;
    assign o_pc_D              = r_pc_D;
    assign o_valid_D           = r_valid_D;
    assign o_is_in_delayslot_D = r_ds_D;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed scenarios followed by a randomized run. A behavioural memory
// answers the instruction port with random latencies and returns a word that
// is a fixed function of its address. The reference model tracks the program
// order the decode stage should see: the next expected PC, whether the next
// delivered instruction is a delay slot, and a pending branch target.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, is_br, br_taken, exc;
    logic [31:0] br_tgt, exc_pc;
    logic [31:0] instr_D, pc_D;
    logic        valid_D, ds_D, adel_D;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .inst_bus            (bus),
        .i_stall_D           (stall),
        .i_flush_D           (flush),
        .i_is_branch_D       (is_br),
        .i_branch_taken_D    (br_taken),
        .i_branch_target_D   (br_tgt),
        .i_exc_redirect      (exc),
        .i_exc_pc            (exc_pc),
        .o_instr_D           (instr_D),
        .o_pc_D              (pc_D),
        .o_valid_D           (valid_D),
        .o_is_in_delayslot_D (ds_D),
        .o_adel_D            (adel_D)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // memory model
    bit          m_out;
    logic [31:0] m_addr;
    int          m_dly;
    int          addr_pct;
    int          dly_min, dly_max;

    // reference model
    logic [31:0] e_pc;
    bit          e_ds, e_tv, m_off;
    logic [31:0] e_tgt;

    // stimulus control
    bit          rnd_mode;
    logic [31:0] dir_br_pc, dir_br_tgt;
    logic [31:0] dq_pc[$];
    bit          dq_ds[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic tick();
        logic        req0, aok0, dok0, rst0, exc0, stall0, flush0, isbr0, tk0, vld0, ds0;
        logic [31:0] addr0, tgt0, epc0, instr0, pc0;
        req0 = bus.inst_req;      addr0 = bus.inst_addr;
        aok0 = bus.inst_addr_ok;  dok0 = bus.inst_data_ok;
        rst0 = rst;  exc0 = exc;  epc0 = exc_pc;  stall0 = stall;  flush0 = flush;
        isbr0 = is_br;  tk0 = br_taken;  tgt0 = br_tgt;
        vld0 = valid_D;  ds0 = ds_D;  instr0 = instr_D;  pc0 = pc_D;

        @(posedge clk);
        #1;

        // memory bookkeeping for the edge just taken
        if (rst0) begin
            m_out = 1'b0;
        end else begin
            if (dok0) m_out = 1'b0;
            if (req0 && aok0) begin
                m_out  = 1'b1;
                m_addr = addr0;
                m_dly  = $urandom_range(dly_max, dly_min);
            end
        end

        if (m_out) chk("req_while_outstanding", bus.inst_req, 1'b0);
        if (!rst0 && req0 && !aok0 && !exc0) begin
            chk("req_held", bus.inst_req, 1'b1);
            chk("addr_stable", bus.inst_addr, addr0);
        end

        // reference model for the edge just taken
        if (rst0) begin
            e_pc = RESET_PC;  e_ds = 1'b0;  e_tv = 1'b0;  m_off = 1'b0;
            chk("rst_req", bus.inst_req, 1'b0);
            chk("rst_instr", instr_D, 32'd0);
            chk("rst_pc_D", pc_D, 32'd0);
            chk("rst_valid", valid_D, 1'b0);
            chk("rst_ds", ds_D, 1'b0);
            chk("rst_adel", adel_D, 1'b0);
        end else if (exc0) begin
            chk("exc_bubble_valid", valid_D, 1'b0);
            chk("exc_bubble_instr", instr_D, 32'd0);
            e_pc = epc0;  e_ds = 1'b0;  e_tv = 1'b0;  m_off = 1'b0;
        end else begin
            if (vld0 && isbr0 && !stall0) begin
                e_ds = 1'b1;
                if (tk0) begin
                    e_tv  = 1'b1;
                    e_tgt = tgt0;
                end
            end
            if (flush0) begin
                chk("flush_valid", valid_D, 1'b0);
                chk("flush_instr", instr_D, 32'd0);
                m_off = 1'b1;
            end else if (stall0) begin
                chk("stall_hold_instr", instr_D, instr0);
                chk("stall_hold_pc", pc_D, pc0);
                chk("stall_hold_valid", valid_D, vld0);
                chk("stall_hold_ds", ds_D, ds0);
            end else if (valid_D) begin
                if (!m_off) begin
                    chk("deliver_pc", pc_D, e_pc);
                    chk("deliver_instr", instr_D, mem_word(e_pc));
                    chk("deliver_ds", ds_D, e_ds);
                    chk("deliver_adel", adel_D, 1'b0);
                    dq_pc.push_back(pc_D);
                    dq_ds.push_back(ds_D);
                    if (e_ds && e_tv) begin
                        e_pc = e_tgt;
                        e_tv = 1'b0;
                    end else begin
                        e_pc = e_pc + 32'd4;
                    end
                    e_ds = 1'b0;
                end
            end else begin
                chk("bubble_instr", instr_D, 32'd0);
                chk("bubble_ds", ds_D, 1'b0);
                chk("bubble_pc_held", pc_D, pc0);
            end
        end

        // memory drive for the coming cycle
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = $urandom;
        if (m_out) begin
            if (m_dly == 0) begin
                bus.inst_data_ok = 1'b1;
                bus.inst_rdata   = mem_word(m_addr);
            end else begin
                m_dly--;
            end
        end
        bus.inst_addr_ok = !m_out && ($urandom_range(99, 0) < addr_pct);

        // branch info follows the instruction currently held in D
        if (rst0 || exc0 || flush0 || !stall0) begin
            is_br = 1'b0;  br_taken = 1'b0;  br_tgt = 32'd0;
            if (valid_D && !ds_D) begin
                if (rnd_mode) begin
                    if ($urandom_range(99, 0) < 30) begin
                        is_br    = 1'b1;
                        br_taken = 1'($urandom_range(1, 0));
                        br_tgt   = $urandom & 32'hFFFF_FFFC;
                    end
                end else if (pc_D == dir_br_pc) begin
                    is_br = 1'b1;  br_taken = 1'b1;  br_tgt = dir_br_tgt;
                end
            end
        end

        if (rnd_mode) begin
            stall  = ($urandom_range(99, 0) < 30);
            exc    = ($urandom_range(99, 0) < 2);
            exc_pc = $urandom & 32'hFFFF_FFFC;
        end
    endtask

    initial begin
        rst = 1'b1;  stall = 1'b0;  flush = 1'b0;  exc = 1'b0;  exc_pc = 32'd0;
        is_br = 1'b0;  br_taken = 1'b0;  br_tgt = 32'd0;
        bus.inst_addr_ok = 1'b0;  bus.inst_data_ok = 1'b0;  bus.inst_rdata = 32'd0;
        m_out = 1'b0;  m_addr = 32'd0;  m_dly = 0;
        addr_pct = 100;  dly_min = 0;  dly_max = 0;
        e_pc = RESET_PC;  e_ds = 1'b0;  e_tv = 1'b0;  e_tgt = 32'd0;  m_off = 1'b0;
        rnd_mode = 1'b0;  dir_br_pc = 32'hFFFF_FFFF;  dir_br_tgt = 32'd0;

        // reset and first fetch
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("first_req", bus.inst_req, 1'b1);
        chk("first_addr", bus.inst_addr, RESET_PC);
        tick();
        tick();
        chk("first_valid", valid_D, 1'b1);
        chk("first_pc_D", pc_D, RESET_PC);
        chk("first_instr", instr_D, mem_word(RESET_PC));

        // stall while the next word returns
        stall = 1'b1;
        tick();
        tick();
        chk("hold_no_req_0", bus.inst_req, 1'b0);
        tick();
        chk("hold_no_req_1", bus.inst_req, 1'b0);
        chk("hold_d_pc", pc_D, RESET_PC);
        stall = 1'b0;
        tick();
        chk("unstall_valid", valid_D, 1'b1);
        chk("unstall_pc_D", pc_D, RESET_PC + 32'd4);
        chk("unstall_next_addr", bus.inst_addr, RESET_PC + 32'd8);

        // taken branch 0x100 -> 0x200 with a slow memory
        dly_min = 2;  dly_max = 2;
        dir_br_pc = 32'h100;  dir_br_tgt = 32'h200;
        exc = 1'b1;  exc_pc = 32'h100;
        tick();
        exc = 1'b0;
        dq_pc.delete();  dq_ds.delete();
        for (int i = 0; i < 60 && dq_pc.size() < 3; i++) tick();
        if (dq_pc.size() < 3) begin
            timeout_fail("branch_seq");
        end else begin
            chk("br_pc0", dq_pc[0], 32'h100);
            chk("br_ds0", dq_ds[0], 1'b0);
            chk("br_pc1", dq_pc[1], 32'h104);
            chk("br_ds1", dq_ds[1], 1'b1);
            chk("br_pc2", dq_pc[2], 32'h200);
            chk("br_ds2", dq_ds[2], 1'b0);
        end
        dir_br_pc = 32'hFFFF_FFFF;

        // exception while waiting on the 0x108 fetch
        dly_min = 3;  dly_max = 3;
        exc = 1'b1;  exc_pc = 32'h108;
        tick();
        exc = 1'b0;
        for (int i = 0; i < 30 && !(bus.inst_req && bus.inst_addr == 32'h108); i++) tick();
        if (!(bus.inst_req && bus.inst_addr == 32'h108)) begin
            timeout_fail("req_0x108");
        end else begin
            tick();
            exc = 1'b1;  exc_pc = 32'hBFC0_0380;
            tick();
            exc = 1'b0;
            dq_pc.delete();  dq_ds.delete();
            for (int i = 0; i < 30 && !bus.inst_req; i++) tick();
            chk("exc_next_req", bus.inst_req, 1'b1);
            chk("exc_next_addr", bus.inst_addr, 32'hBFC0_0380);
            for (int i = 0; i < 30 && dq_pc.size() == 0; i++) tick();
            if (dq_pc.size() == 0) timeout_fail("exc_delivery");
            else chk("exc_first_pc", dq_pc[0], 32'hBFC0_0380);
        end

        // flush together with stall
        dly_min = 0;  dly_max = 0;
        for (int i = 0; i < 30 && !valid_D; i++) tick();
        if (!valid_D) begin
            timeout_fail("valid_before_flush");
        end else begin
            stall = 1'b1;  flush = 1'b1;
            tick();
            chk("flush_stall_valid", valid_D, 1'b0);
            chk("flush_stall_instr", instr_D, 32'd0);
            stall = 1'b0;  flush = 1'b0;
        end

`ifdef FETCH_ADEL_EN
        // misaligned redirect
        exc = 1'b1;  exc_pc = 32'h202;
        tick();
        exc = 1'b0;
        m_off = 1'b1;
        chk("adel_no_req", bus.inst_req, 1'b0);
        tick();
        chk("adel_flag", adel_D, 1'b1);
        chk("adel_valid", valid_D, 1'b1);
        chk("adel_pc_D", pc_D, 32'h202);
        chk("adel_instr", instr_D, 32'd0);
        chk("adel_still_no_req", bus.inst_req, 1'b0);
`endif

        // randomized run
        addr_pct = 70;  dly_min = 0;  dly_max = 3;
        exc = 1'b1;  exc_pc = 32'h0000_1000;
        tick();
        exc = 1'b0;
        rnd_mode = 1'b1;
        for (int i = 0; i < 2500; i++) tick();
        rnd_mode = 1'b0;
        stall = 1'b0;  exc = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register. It owns the fetch PC and drives a single-outstanding SRAM-like instruction port. It delivers `instr_D`/`pc_D` to the decode stage, whose main decoder consumes `instr_D`. It also applies delayed-branch redirects after the delay slot, applies exception redirects immediately (cancelling in-flight fetches), and inserts NOP bubbles when no instruction is ready.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall_D`  in  1  decode holds; D register must not change
- `flush_D`  in  1  replace D contents with bubble
- `is_branch_D`  in  1  valid instruction in D is a branch/jump (has delay slot)
- `branch_taken_D`  in  1  that branch redirects
- `branch_target_D`  in  32  redirect target
- `exc_redirect`  in  1  exception/eret redirect, highest priority
- `exc_pc`  in  32  exception/eret target
- `inst_req`  out  1  fetch request
- `inst_addr`  out  32  fetch address
- `inst_addr_ok`  in  1  request accepted this cycle
- `inst_data_ok`  in  1  read data valid this cycle
- `inst_rdata`  in  32  read data
- `instr_D`  out  32  instruction to decode (0 = NOP bubble)
- `pc_D`  out  32  PC of `instr_D`
- `valid_D`  out  1  `instr_D` is a real instruction
- `is_in_delayslot_D`  out  1  `instr_D` is a delay-slot instruction
- `adel_D`  out  1  fetch address misaligned (see Configuration)

## Operation
- FSM states: REQ, WAIT, CANCEL, HOLD. `inst_req = (state==REQ)`. `inst_addr = pc_F`.
- REQ: on `inst_addr_ok` go to WAIT.
- WAIT: on `inst_data_ok` with `!stall_D`, deliver to D and go to REQ with next PC. On `inst_data_ok` with `stall_D`, latch `inst_rdata` into a 1-entry buffer and go to HOLD.
- HOLD: when `!stall_D`, deliver the buffer and go to REQ.
- CANCEL: wait for `inst_data_ok`, discard the data, then go to REQ.
- Delivery: `instr_D<=data`, `pc_D<=pc_F`, `valid_D<=1`, `is_in_delayslot_D<=ds_flag`, then clear `ds_flag`.
- Any cycle without delivery and without `stall_D`: D gets a bubble (`instr_D=0`, `valid_D=0`, `pc_D` unchanged, flags 0).
- Branch capture: when `valid_D & is_branch_D & !stall_D`, set `ds_flag`. If `branch_taken_D` is also high, set `pend_valid` and `pend_pc<=branch_target_D`.
- Next PC after a delivery:
  - delivery with `ds_flag` set (the delay slot) and `pend_valid` set: next PC is `pend_pc`, and `pend_valid` clears;
  - otherwise next PC is `pc_F+4`, wrapping mod 2^32.
- Exception redirect, `exc_redirect`, overrides everything:
  - sets `pc_F<=exc_pc`;
  - clears `pend_valid`, `ds_flag`, D (bubble) and the buffer;
  - next state: from WAIT (no data_ok) go to CANCEL; from REQ with `inst_addr_ok` go to CANCEL; from WAIT with data_ok, REQ without addr_ok, HOLD or CANCEL go to REQ (CANCEL stays in CANCEL if data is still pending).
- `flush_D`: D becomes a bubble this edge. It overrides both `stall_D` and a delivery; that delivered word is lost, and the PC still advances.

## Timing
- Reset values: `state=REQ`, `pc_F=RESET_PC`, `instr_D=0`, `pc_D=0`, `valid_D=0`, `is_in_delayslot_D=0`, `adel_D=0`, `pend_valid=0`, `ds_flag=0`.
- `inst_req` is 0 while `rst` is high and is 1 in the first cycle after release.
- Best case: req+addr_ok in cycle N, data_ok in N+1, `instr_D` valid from N+2.
- At most one outstanding request, so throughput is 1 instruction per 2 cycles.
- `inst_addr` is stable while `inst_req` is high and `inst_addr_ok` is low.

## Configuration
- `FETCH_ADEL_EN` defined:
  - in REQ with `pc_F[1:0]!=0`, no request is issued (`inst_req=0`);
  - next non-stalled edge delivers `instr_D=0`, `valid_D=1`, `adel_D=1`, `pc_D=pc_F`;
  - FSM stays in REQ; `pc_F` is held until `exc_redirect`.
- Undefined: `adel_D` is tied to 0, and `pc_F[1:0]` is ignored (address sent as-is).

## Test plan
- Reset: release `rst`; the first request is `inst_addr=0xBFC00000`. With addr_ok and data_ok=1 next cycle, `instr_D=rdata`, `pc_D=0xBFC00000` two cycles after the request.
- Stall during return: data_ok with `stall_D=1` for 3 cycles. D holds, the FSM is in HOLD, and no `inst_req`. Delivery occurs on the first cycle after stall release; the next address is +4.
- Taken branch at 0x100 → 0x200 with a 4-cycle delay-slot latency: delivered PCs are 0x100, 0x104 (`is_in_delayslot_D=1`), 0x200, with bubbles in between.
- Exception while WAIT on 0x108 with `exc_pc=0xBFC00380`: the data from 0x108 is discarded (never valid in D); the next request is 0xBFC00380.
- `flush_D` and `stall_D` together: D becomes a bubble (`valid_D=0`, `instr_D=0`).
- With `FETCH_ADEL_EN`, redirect to 0x202: no `inst_req`; `adel_D=1`, `pc_D=0x202`, `instr_D=0`.
